// File: rtl/decoder_pkg.sv
// Shared types and helpers for the timed 3-to-8 strobe decoder.
package decoder_pkg;

    typedef enum logic [1:0] {IDLE, ACTIVE, GAP} dec_state_t;

    typedef struct packed {
        logic [2:0] code;
        logic       none;
    } dec_req_t;

    function automatic logic [7:0] onehot38(dec_req_t req);
        logic [7:0] line;
        line = 8'h01 << req.code;
        return req.none ? 8'h00 : line;
    endfunction

    // Counter must hold the larger of the two phase lengths.
    function automatic int cnt_width(int hold, int gap);
        int m;
        m = (hold > gap) ? hold : gap;
        return $clog2(m + 1);
    endfunction

endpackage

// File: rtl/decoder38_comb.sv
// Pure combinational {code, none} to one-hot line decode.
module decoder38_comb
    import decoder_pkg::*;
(
    input  dec_req_t   req_i,
    output logic [7:0] line_o
);

    assign line_o = onehot38(req_i);

endmodule

// File: rtl/decoder38_strobe.sv
// Registered 3-to-8 strobe decoder with timed hold and break-before-make gap.
// Optional one-entry request buffer enabled by defining DECODER38_QUEUE_EN.
module decoder38_strobe
    import decoder_pkg::*;
#(
    parameter int HOLD_CYCLES = 4,
    parameter int GAP_CYCLES  = 1
)
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid,
    input  logic [2:0] in_code,
    input  logic       in_none,
    output logic       in_ready,
    output logic [7:0] out,
    output logic       busy,
    output logic       done
);

    localparam int CW = cnt_width(HOLD_CYCLES, GAP_CYCLES);
    localparam logic [CW-1:0] HOLD_LD = CW'(HOLD_CYCLES - 1);
    localparam logic [CW-1:0] GAP_LD  = (GAP_CYCLES > 0) ? CW'(GAP_CYCLES - 1) : '0;

    dec_state_t     state_q, state_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [7:0]     out_q, out_d;
    dec_req_t       inReq;
    dec_req_t       startReq;
    logic [7:0]     lineSel;
    logic           accept;
    logic           start;
    logic           cntZero;
    logic           strobeEnd;

    assign inReq     = '{code: in_code, none: in_none};
    assign accept    = in_valid && in_ready;
    assign cntZero   = (cnt_q == '0);
    assign strobeEnd = (state_q == ACTIVE && cntZero && GAP_CYCLES == 0) ||
                       (state_q == GAP && cntZero);

`ifdef DECODER38_QUEUE_EN
    dec_req_t buf_q, buf_d;
    logic     bufFull_q, bufFull_d;

    // A pending request launches on the edge the current strobe would go idle.
    assign in_ready = !bufFull_q && rst_n;
    assign start    = (state_q == IDLE || strobeEnd) && (bufFull_q || accept);
    assign startReq = bufFull_q ? buf_q : inReq;

    always_comb begin
        buf_d     = buf_q;
        bufFull_d = bufFull_q;
        if (start && bufFull_q) begin
            bufFull_d = accept;
            if (accept) begin
                buf_d = inReq;
            end
        end else if (accept && !start) begin
            bufFull_d = 1'b1;
            buf_d     = inReq;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            buf_q     <= '0;
            bufFull_q <= 1'b0;
        end else begin
            buf_q     <= buf_d;
            bufFull_q <= bufFull_d;
        end
    end
`else
    assign in_ready = (state_q == IDLE) && rst_n;
    assign start    = accept;
    assign startReq = inReq;
`endif

    decoder38_comb u_comb (
        .req_i  (startReq),
        .line_o (lineSel)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            out_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            out_q   <= out_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (start) begin
            state_d = ACTIVE;
            cnt_d   = HOLD_LD;
        end else begin
            case (state_q)
                IDLE: begin
                    state_d = IDLE;
                end
                ACTIVE: begin
                    if (cntZero) begin
                        if (GAP_CYCLES > 0) begin
                            state_d = GAP;
                            cnt_d   = GAP_LD;
                        end else begin
                            state_d = IDLE;
                        end
                    end else begin
                        cnt_d = cnt_q - CW'(1);
                    end
                end
                GAP: begin
                    if (cntZero) begin
                        state_d = IDLE;
                    end else begin
                        cnt_d = cnt_q - CW'(1);
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    // Line holds only while ACTIVE has cycles left; otherwise it drops to zero.
    always_comb begin
        out_d = '0;
        if (start) begin
            out_d = lineSel;
        end else if (state_q == ACTIVE && !cntZero) begin
            out_d = out_q;
        end
    end

    always_comb begin
        out  = out_q;
        busy = (state_q != IDLE);
        done = (state_q == ACTIVE) && cntZero;
    end

endmodule

// File: tb/tb_decoder38_strobe.sv
// Directed self-checking bench for decoder38_strobe (three parameterisations).
module tb_decoder38_strobe;

`ifdef DECODER38_QUEUE_EN
    localparam bit QUEUE = 1'b1;
`else
    localparam bit QUEUE = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n;
    logic       validV [3];
    logic [2:0] codeV  [3];
    logic       noneV  [3];
    logic       readyW [3];
    logic [7:0] outW   [3];
    logic       busyW  [3];
    logic       doneW  [3];

    int         testsRun = 0;
    int         testsFailed = 0;
    int         unitSel = 0;
    logic [3:0] pend [$];

    always #5 clk = ~clk;

    decoder38_strobe #(.HOLD_CYCLES(4), .GAP_CYCLES(1)) dutA (
        .clk(clk), .rst_n(rst_n), .in_valid(validV[0]), .in_code(codeV[0]),
        .in_none(noneV[0]), .in_ready(readyW[0]), .out(outW[0]),
        .busy(busyW[0]), .done(doneW[0])
    );

    decoder38_strobe #(.HOLD_CYCLES(4), .GAP_CYCLES(0)) dutZ (
        .clk(clk), .rst_n(rst_n), .in_valid(validV[1]), .in_code(codeV[1]),
        .in_none(noneV[1]), .in_ready(readyW[1]), .out(outW[1]),
        .busy(busyW[1]), .done(doneW[1])
    );

    decoder38_strobe #(.HOLD_CYCLES(1), .GAP_CYCLES(1)) dutH (
        .clk(clk), .rst_n(rst_n), .in_valid(validV[2]), .in_code(codeV[2]),
        .in_none(noneV[2]), .in_ready(readyW[2]), .out(outW[2]),
        .busy(busyW[2]), .done(doneW[2])
    );

    task automatic checkOutput(input string tag, input logic [7:0] observed,
                               input logic [7:0] expected);
        testsRun++;
        if (observed !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
        end
    endtask

    // Present the head of the pending list to the selected unit, or go quiet.
    task automatic presentHead();
        logic [3:0] r;
        if (pend.size() > 0) begin
            r = pend[0];
            validV[unitSel] = 1'b1;
            codeV[unitSel]  = r[3:1];
            noneV[unitSel]  = r[0];
        end else begin
            validV[unitSel] = 1'b0;
        end
    endtask

    task automatic applyStimulus(input int u);
        unitSel = u;
        presentHead();
    endtask

    // One clock: handshake bookkeeping at the edge, then check on the falling edge.
    task automatic tickCheck(input string tag, input int i, input logic [7:0] eOut,
                             input bit eBusy, input bit eDone, input bit eReady);
        bit readySeen;
        bit accepted;
        readySeen = readyW[unitSel];
        @(posedge clk);
        accepted = validV[unitSel] && readySeen;
        @(negedge clk);
        if (accepted) begin
            void'(pend.pop_front());
            presentHead();
        end
        checkOutput($sformatf("%s.%0d.out", tag, i), outW[unitSel], eOut);
        checkOutput($sformatf("%s.%0d.busy", tag, i), {7'b0, busyW[unitSel]}, {7'b0, eBusy});
        checkOutput($sformatf("%s.%0d.done", tag, i), {7'b0, doneW[unitSel]}, {7'b0, eDone});
        checkOutput($sformatf("%s.%0d.ready", tag, i), {7'b0, readyW[unitSel]}, {7'b0, eReady});
    endtask

    initial begin
        rst_n = 1'b0;
        for (int u = 0; u < 3; u++) begin
            validV[u] = 1'b0;
            codeV[u]  = 3'd0;
            noneV[u]  = 1'b0;
        end
        repeat (2) @(negedge clk);
        checkOutput("rst.readyLow", {7'b0, readyW[0]}, 8'h00);
        checkOutput("rst.out", outW[0], 8'h00);
        rst_n = 1'b1;
        #1;
        checkOutput("rel.ready", {7'b0, readyW[0]}, 8'h01);
        checkOutput("rel.busy", {7'b0, busyW[0]}, 8'h00);
        checkOutput("rel.done", {7'b0, doneW[0]}, 8'h00);
        checkOutput("rel.out", outW[0], 8'h00);

        // Plain strobe of line 5.
        pend.push_back({3'd5, 1'b0});
        applyStimulus(0);
        for (int i = 1; i <= 6; i++)
            tickCheck("t1", i, (i <= 4) ? 8'h20 : 8'h00, i <= 5, i == 4, QUEUE || i == 6);

        // Blank strobe: same timing, no line.
        pend.push_back({3'd3, 1'b1});
        applyStimulus(0);
        for (int i = 1; i <= 6; i++)
            tickCheck("t2", i, 8'h00, i <= 5, i == 4, QUEUE || i == 6);

        // Two requests held upstream while busy.
        pend.push_back({3'd7, 1'b0});
        pend.push_back({3'd0, 1'b0});
        applyStimulus(0);
        for (int i = 1; i <= 13; i++) begin
            if (QUEUE)
                tickCheck("t3", i, (i <= 4) ? 8'h80 : (i >= 6 && i <= 9) ? 8'h01 : 8'h00,
                          i <= 10, i == 4 || i == 9, i == 1 || i >= 6);
            else
                tickCheck("t3", i, (i <= 4) ? 8'h80 : (i >= 7 && i <= 10) ? 8'h01 : 8'h00,
                          i <= 5 || (i >= 7 && i <= 11), i == 4 || i == 10, i == 6 || i >= 12);
        end

        // Asynchronous reset in the middle of a strobe.
        pend.push_back({3'd2, 1'b0});
        applyStimulus(0);
        for (int i = 1; i <= 2; i++)
            tickCheck("t4", i, 8'h04, 1'b1, 1'b0, QUEUE);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("t4.rst.out", outW[0], 8'h00);
        checkOutput("t4.rst.ready", {7'b0, readyW[0]}, 8'h00);
        checkOutput("t4.rst.busy", {7'b0, busyW[0]}, 8'h00);
        checkOutput("t4.rst.done", {7'b0, doneW[0]}, 8'h00);
        @(negedge clk);
        rst_n = 1'b1;
        tickCheck("t4post", 1, 8'h00, 1'b0, 1'b0, 1'b1);

        // No gap, back-to-back codes 0 and 1.
        pend.push_back({3'd0, 1'b0});
        pend.push_back({3'd1, 1'b0});
        applyStimulus(1);
        for (int i = 1; i <= 10; i++) begin
            if (QUEUE)
                tickCheck("t5", i, (i <= 4) ? 8'h01 : (i <= 8) ? 8'h02 : 8'h00,
                          i <= 8, i == 4 || i == 8, i == 1 || i >= 5);
            else
                tickCheck("t5", i, (i <= 4) ? 8'h01 : (i >= 6 && i <= 9) ? 8'h02 : 8'h00,
                          i <= 4 || (i >= 6 && i <= 9), i == 4 || i == 9, i == 5 || i >= 10);
        end

        // Single-cycle hold: line and done coincide.
        pend.push_back({3'd6, 1'b0});
        applyStimulus(2);
        for (int i = 1; i <= 3; i++)
            tickCheck("t6", i, (i == 1) ? 8'h40 : 8'h00, i <= 2, i == 1, QUEUE || i == 3);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
